// File: rtl/mac_reg_pkg.sv
// mac_reg_pkg: shared definitions for the MAC register access arbiter.
//   - FSM state encoding
//   - default MCI address/data widths
//   - timeout counter width and the read-data fill bit used on timeout
package mac_reg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefAddrW = 14;
    localparam int unsigned DefDataW = 32;
    localparam int unsigned ToCntW   = 16;

    // Replicated to DATA_W bits, so a timed-out read returns all-ones.
    localparam bit RdFillBit = 1'b1;

endpackage

// File: rtl/mac_reg_rr_arb.sv
// mac_reg_rr_arb: combinational round-robin arbiter.
// Ports:
//   req        in   NUM_CH  request vector
//   last_grant in   IDX_W   index of the previous winner (registered by parent)
//   gnt        out  NUM_CH  one-hot grant (all zero when no request)
//   gnt_idx    out  IDX_W   encoded grant index (0 when no request)
// The search starts at last_grant+1 and wraps around to last_grant.
module mac_reg_rr_arb #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        // First pass: channels above last_grant, in ascending order.
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && req[c] && (c > int'(last_grant))) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
        // Second pass: wrap around to channels at or below last_grant.
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && req[c] && (c <= int'(last_grant))) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/mac_reg_access_arb.sv
// mac_reg_access_arb: round-robin bridge from NUM_CH register requesters onto
// one MAC control interface (MCI).
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_req/i_rdwn         per-channel request level and direction (1 = read)
//   i_addr/i_wdata/i_be  per-channel fields, channel c at [c*W +: W]
//   o_done/o_err         one-cycle completion pulse / timeout flag per channel
//   o_rdata              read data, valid with o_done
//   o_mci_*              MCI request (valid, addr, wdata, be, rdwn)
//   i_mci_ack/i_mci_rdata MCI completion and read data
// Optional feature: define MAC_REG_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYC cycles without an ack. Otherwise WAIT lasts until ack and o_err is 0.
module mac_reg_access_arb
    import mac_reg_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH-1:0]        i_rdwn,
    input  logic [NUM_CH*ADDR_W-1:0] i_addr,
    input  logic [NUM_CH*DATA_W-1:0] i_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] i_be,
    output logic [NUM_CH-1:0]        o_done,
    output logic [NUM_CH-1:0]        o_err,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_mci_val,
    output logic [ADDR_W-1:0]        o_mci_addr,
    output logic [DATA_W-1:0]        o_mci_wdata,
    output logic [DATA_W/8-1:0]      o_mci_be,
    output logic                     o_mci_rdwn,
    input  logic                     i_mci_ack,
    input  logic [DATA_W-1:0]        i_mci_rdata
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BE_W  = DATA_W / 8;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                val_q, val_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                rdwn_q, rdwn_d;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic [NUM_CH-1:0]   grant_oh;
    logic                timeout_fire;

    logic                sel_rdwn;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;

    mac_reg_rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arb (
        .req        (i_req),
        .last_grant (last_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    // One-hot mux of the winner's fields.
    always_comb begin
        sel_rdwn  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_gnt[c]) begin
                sel_rdwn  = i_rdwn[c];
                sel_addr  = i_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = i_wdata[c*DATA_W +: DATA_W];
                sel_be    = i_be[c*BE_W +: BE_W];
            end
        end
    end

    // last_q doubles as the current grant once a transaction is in flight.
    always_comb begin
        grant_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_oh[c] = (last_q == IDX_W'(c));
        end
    end

`ifdef MAC_REG_TIMEOUT_EN
    logic [ToCntW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0] err_q, err_d;

    // Count 0..TIMEOUT_CYC-1 gives exactly TIMEOUT_CYC cycles of o_mci_val.
    assign timeout_fire = (state_q == StWait) && (cnt_q == ToCntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != StWait) begin
            cnt_d = '0;
        end else if (!i_mci_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_fire       = 1'b0;
    assign o_err              = '0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        done_d  = '0;
        rdata_d = '0;
        val_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        rdwn_d  = 1'b0;
`ifdef MAC_REG_TIMEOUT_EN
        err_d   = '0;
`endif
        case (state_q)
            StIdle: begin
                if (|i_req) begin
                    state_d = StWait;
                    last_d  = arb_idx;
                    val_d   = 1'b1;
                    addr_d  = sel_addr;
                    wdata_d = sel_rdwn ? '0 : sel_wdata;
                    be_d    = sel_be;
                    rdwn_d  = sel_rdwn;
                end
            end
            StWait: begin
                // Ack takes priority over a simultaneous timeout.
                if (i_mci_ack) begin
                    state_d = StDone;
                    done_d  = grant_oh;
                    if (rdwn_q) begin
                        rdata_d = i_mci_rdata;
                    end
                end else if (timeout_fire) begin
                    state_d = StDone;
                    done_d  = grant_oh;
                    rdata_d = {DATA_W{RdFillBit}};
`ifdef MAC_REG_TIMEOUT_EN
                    err_d   = grant_oh;
`endif
                end else begin
                    val_d   = 1'b1;
                    addr_d  = addr_q;
                    wdata_d = wdata_q;
                    be_d    = be_q;
                    rdwn_d  = rdwn_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            last_q  <= IDX_W'(NUM_CH - 1);
            done_q  <= '0;
            rdata_q <= '0;
            val_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdwn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            val_q   <= val_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdwn_q  <= rdwn_d;
        end
    end

    assign o_done      = done_q;
    assign o_rdata     = rdata_q;
    assign o_mci_val   = val_q;
    assign o_mci_addr  = addr_q;
    assign o_mci_wdata = wdata_q;
    assign o_mci_be    = be_q;
    assign o_mci_rdwn  = rdwn_q;

endmodule
